// File: rtl/variable_delay_buffer.sv
// variable_delay_buffer: runtime-programmable delay line built on a circular RAM buffer
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   run       pulse: latch delay, clear pointers/fill state, restart the stream
//   running   level: each edge with running=1 and run=0 is one advance
//   delay     extra delay D in advances, sampled on run
//   in0       input sample, captured on each advance
//   out0      registered delayed sample
//   out_valid out0 holds a sample written since the last run
module variable_delay_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              running,
  input  logic [ADDR_W-1:0] delay,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic              out_valid
);
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wptr, fill_cnt, d, rptr;
  logic adv, emit;
  assign adv = running && !run && state != IDLE;
  assign rptr = wptr - d;
  // fill_cnt saturates at d, so in STREAM the equality also holds
  assign emit = adv && fill_cnt == d;
  always_comb begin
    state_nxt = state;
    state_nxt = run ? FILL : (adv && state == FILL && fill_cnt == d) ? STREAM : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (adv) mem[wptr] <= in0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      fill_cnt <= '0;
      d <= '0;
      out0 <= '0;
      out_valid <= 1'b0;
    end else if (run) begin
      d <= delay;
      wptr <= '0;
      fill_cnt <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      wptr <= wptr + 1'b1;
      if (fill_cnt < d) fill_cnt <= fill_cnt + 1'b1;
      if (emit) begin
        // d==0 reads the word being written this cycle, so bypass the RAM
        out0 <= (d == '0) ? in0 : mem[rptr];
        out_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_variable_delay_buffer.sv
// tb_variable_delay_buffer: directed self-checking bench for variable_delay_buffer
module tb_variable_delay_buffer;
  logic        clk = 1'b0;
  logic        rst, run, running;
  logic [5:0]  delay;
  logic [31:0] in0, out0;
  logic        out_valid;
  int total = 0;
  int bad = 0;
  variable_delay_buffer #(.DATA_W(32), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .delay(delay),
    .in0(in0), .out0(out0), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b0; run = 1'b0; running = 1'b0; delay = '0; in0 = '0;
    repeat (3) tick;
    chk("reset_out0", out0, 32'h0);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    rst = 1'b1;
    running = 1'b1; in0 = 32'hAA;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("idle_out0", out0, 32'h0);
      chk("idle_valid", {31'b0, out_valid}, 32'h0);
    end
    run = 1'b1; delay = 6'd0;
    tick;
    run = 1'b0;
    chk("d0_run_valid", {31'b0, out_valid}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      in0 = i;
      tick;
      chk("d0_out0", out0, i);
      chk("d0_valid", {31'b0, out_valid}, 32'h1);
    end
    run = 1'b1; delay = 6'd3; in0 = 32'hBAD;
    tick;
    run = 1'b0;
    chk("d3_run_valid", {31'b0, out_valid}, 32'h0);
    chk("d3_run_hold", out0, 32'h4);
    for (int i = 0; i < 8; i++) begin
      in0 = 32'h10 + i;
      tick;
      if (i < 3) chk("d3_fill_valid", {31'b0, out_valid}, 32'h0);
      else begin
        chk("d3_out0", out0, 32'h10 + i - 3);
        chk("d3_valid", {31'b0, out_valid}, 32'h1);
      end
    end
    running = 1'b0; in0 = 32'hDEAD;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("stall_out0", out0, 32'h14);
      chk("stall_valid", {31'b0, out_valid}, 32'h1);
    end
    running = 1'b1;
    for (int i = 8; i < 12; i++) begin
      in0 = 32'h10 + i;
      tick;
      chk("resume_out0", out0, 32'h10 + i - 3);
    end
    run = 1'b1; delay = 6'd63; in0 = 32'hBEEF;
    tick;
    run = 1'b0;
    chk("max_run_valid", {31'b0, out_valid}, 32'h0);
    chk("max_run_hold", out0, 32'h18);
    for (int k = 0; k < 70; k++) begin
      in0 = k;
      tick;
      if (k < 63) chk("max_fill_valid", {31'b0, out_valid}, 32'h0);
      else begin
        chk("max_out0", out0, k - 63);
        chk("max_valid", {31'b0, out_valid}, 32'h1);
      end
    end
    #3 rst = 1'b0;
    #1;
    chk("async_out0", out0, 32'h0);
    chk("async_valid", {31'b0, out_valid}, 32'h0);
    tick;
    rst = 1'b1;
    in0 = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_idle", {31'b0, out_valid}, 32'h0);
    end
    run = 1'b1; delay = 6'd2;
    tick;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in0 = 32'h50 + i;
      tick;
      if (i < 2) chk("post_rst_fill", {31'b0, out_valid}, 32'h0);
      else chk("post_rst_out0", out0, 32'h50 + i - 2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
